// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand selection, load-use/RAW stall and flush.
// Define ID_EX_BYPASS_EN to forward MEM/WB results instead of stalling on non-load producers.
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       in_alu_control,
    input  logic [4:0]        in_rs_addr,
    input  logic [4:0]        in_rt_addr,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [15:0]       in_imm,
    input  logic              in_imm_zext,
    input  logic [4:0]        in_sa,
    input  logic              in_src1_is_sa,
    input  logic              in_src2_is_imm,
    input  logic [4:0]        in_dest,
    input  logic              flush,
    input  logic              mem_wen,
    input  logic [4:0]        mem_dest,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_is_load,
    input  logic              wb_wen,
    input  logic [4:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       alu_control,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [4:0]        out_dest
);

    function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm, input logic zext);
        return zext ? {{(DATA_W-16){1'b0}}, imm} : {{(DATA_W-16){imm[15]}}, imm};
    endfunction

    logic              rs_used, rt_used;
    logic              mem_rs, mem_rt, wb_rs, wb_rt;
    logic              hazard_stall, capture;
    logic [DATA_W-1:0] rs_res, rt_res, src1_d, src2_d;

    logic              vld_p0;
    logic [11:0]       ctrl_p0;
    logic [DATA_W-1:0] src1_p0, src2_p0;
    logic [4:0]        dest_p0;

    // Register 0 is hard-wired, so a zero address can never collide with a producer.
    assign rs_used = !in_src1_is_sa && (in_rs_addr != 5'd0);
    assign rt_used = !in_src2_is_imm && (in_rt_addr != 5'd0);
    assign mem_rs  = rs_used && mem_wen && (mem_dest == in_rs_addr);
    assign mem_rt  = rt_used && mem_wen && (mem_dest == in_rt_addr);
    assign wb_rs   = rs_used && wb_wen && (wb_dest == in_rs_addr);
    assign wb_rt   = rt_used && wb_wen && (wb_dest == in_rt_addr);

`ifdef ID_EX_BYPASS_EN
    // Only a load in MEM is too late to forward; everything else bypasses, MEM first.
    assign hazard_stall = in_valid && mem_is_load && (mem_rs || mem_rt);
    assign rs_res = (mem_rs && !mem_is_load) ? mem_wdata :
                    wb_rs                    ? wb_wdata  : in_rs_val;
    assign rt_res = (mem_rt && !mem_is_load) ? mem_wdata :
                    wb_rt                    ? wb_wdata  : in_rt_val;
`else
    logic unused_bypass_inputs;
    assign unused_bypass_inputs = ^{mem_wdata, wb_wdata, mem_is_load};
    assign hazard_stall = in_valid && (mem_rs || mem_rt || wb_rs || wb_rt);
    assign rs_res = in_rs_val;
    assign rt_res = in_rt_val;
`endif

    assign src1_d = in_src1_is_sa ? {{(DATA_W-5){1'b0}}, in_sa} : rs_res;
    assign src2_d = in_src2_is_imm ? ext_imm(in_imm, in_imm_zext) : rt_res;

    assign in_ready = flush || ((!vld_p0 || out_ready) && !hazard_stall);
    assign capture  = in_valid && in_ready && !flush;

    // ---- stage p0: ID/EX register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            ctrl_p0 <= '0;
            src1_p0 <= '0;
            src2_p0 <= '0;
            dest_p0 <= '0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
        end else if (capture) begin
            vld_p0  <= 1'b1;
            ctrl_p0 <= in_alu_control;
            src1_p0 <= src1_d;
            src2_p0 <= src2_d;
            dest_p0 <= in_dest;
        end else if (out_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign out_valid   = vld_p0;
    assign alu_control = vld_p0 ? ctrl_p0 : 12'b0;
    assign alu_src1    = src1_p0;
    assign alu_src2    = src2_p0;
    assign out_dest    = dest_p0;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table, hand-written corner sequences and a randomized
// run against a behavioural model of the ID/EX stage.
module tb_id_ex_stage;

`ifdef ID_EX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_alu_control;
    logic [4:0]  in_rs_addr, in_rt_addr;
    logic [31:0] in_rs_val, in_rt_val;
    logic [15:0] in_imm;
    logic        in_imm_zext;
    logic [4:0]  in_sa;
    logic        in_src1_is_sa, in_src2_is_imm;
    logic [4:0]  in_dest;
    logic        flush;
    logic        mem_wen;
    logic [4:0]  mem_dest;
    logic [31:0] mem_wdata;
    logic        mem_is_load;
    logic        wb_wen;
    logic [4:0]  wb_dest;
    logic [31:0] wb_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] alu_control;
    logic [31:0] alu_src1, alu_src2;
    logic [4:0]  out_dest;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_control(in_alu_control),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .in_imm(in_imm), .in_imm_zext(in_imm_zext),
        .in_sa(in_sa), .in_src1_is_sa(in_src1_is_sa),
        .in_src2_is_imm(in_src2_is_imm), .in_dest(in_dest),
        .flush(flush),
        .mem_wen(mem_wen), .mem_dest(mem_dest), .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
        .wb_wen(wb_wen), .wb_dest(wb_dest), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .out_dest(out_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        in_valid = 1'b0; in_alu_control = '0;
        in_rs_addr = '0; in_rt_addr = '0; in_rs_val = '0; in_rt_val = '0;
        in_imm = '0; in_imm_zext = 1'b0; in_sa = '0;
        in_src1_is_sa = 1'b0; in_src2_is_imm = 1'b0; in_dest = '0;
        flush = 1'b0; out_ready = 1'b1;
        mem_wen = 1'b0; mem_dest = '0; mem_wdata = '0; mem_is_load = 1'b0;
        wb_wen = 1'b0; wb_dest = '0; wb_wdata = '0;
    endtask

    typedef struct {
        logic [11:0] op;
        logic [4:0]  rs, rt;
        logic [31:0] rsv, rtv;
        logic [15:0] imm;
        logic        zext;
        logic [4:0]  sa;
        logic        s1sa, s2imm;
        logic        mwen;
        logic [4:0]  mdest;
        logic [31:0] mdata;
        logic        mload;
        logic        wwen;
        logic [4:0]  wdest;
        logic [31:0] wdata;
        logic        ready;
        logic [31:0] src1, src2;
    } vec_t;

    vec_t tbl[10];

    // Behavioural model: a source operand is a list of register reads; a read stalls if a
    // producer it cannot obtain in time targets it, otherwise it takes the youngest producer.
    logic        m_vld;
    logic [11:0] m_ctrl;
    logic [31:0] m_s1, m_s2;
    logic [4:0]  m_dest;

    function automatic bit model_stall();
        logic [4:0] reads[$];
        bit st = 1'b0;
        if (!in_valid) return 1'b0;
        if (!in_src1_is_sa)  reads.push_back(in_rs_addr);
        if (!in_src2_is_imm) reads.push_back(in_rt_addr);
        foreach (reads[k]) begin
            if (reads[k] != 5'd0) begin
                if (mem_wen && mem_dest == reads[k] && (mem_is_load || !BYP)) st = 1'b1;
                if (!BYP && wb_wen && wb_dest == reads[k]) st = 1'b1;
            end
        end
        return st;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic [31:0] rf);
        if (BYP && a != 5'd0 && mem_wen && !mem_is_load && mem_dest == a) return mem_wdata;
        if (BYP && a != 5'd0 && wb_wen && wb_dest == a) return wb_wdata;
        return rf;
    endfunction

    function automatic logic [31:0] model_imm();
        int v;
        v = in_imm_zext ? int'(in_imm) : int'($signed(in_imm));
        return 32'(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_rdy;
        logic [31:0] n_s1, n_s2;

        tbl[0] = '{12'h800, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0000, 1'b0, 5'd0, 1'b0, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'd5, 32'd7};
        tbl[1] = '{12'h400, 5'd1, 5'd2, 32'd5, 32'd7, 16'h8000, 1'b0, 5'd0, 1'b0, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'd5, 32'hFFFF8000};
        tbl[2] = '{12'h020, 5'd1, 5'd2, 32'd5, 32'd7, 16'h8000, 1'b1, 5'd0, 1'b0, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'd5, 32'h00008000};
        tbl[3] = '{12'h008, 5'd3, 5'd2, 32'd9, 32'd7, 16'h0000, 1'b0, 5'd17, 1'b1, 1'b0,
                   1'b1, 5'd3, 32'hDEAD, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'd17, 32'd7};
        tbl[4] = '{12'h800, 5'd3, 5'd0, 32'd1, 32'd0, 16'h0004, 1'b0, 5'd0, 1'b0, 1'b1,
                   1'b1, 5'd3, 32'hAA, 1'b0, 1'b1, 5'd3, 32'hBB, BYP, 32'hAA, 32'd4};
        tbl[5] = '{12'h100, 5'd0, 5'd5, 32'd9, 32'd3, 16'h0000, 1'b0, 5'd0, 1'b0, 1'b0,
                   1'b1, 5'd0, 32'hAA, 1'b0, 1'b1, 5'd0, 32'hBB, 1'b1, 32'd9, 32'd3};
        tbl[6] = '{12'h200, 5'd1, 5'd6, 32'd11, 32'd22, 16'h0000, 1'b0, 5'd0, 1'b0, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd6, 32'd33, BYP, 32'd11, 32'd33};
        tbl[7] = '{12'h040, 5'd7, 5'd8, 32'd1, 32'd2, 16'h0000, 1'b0, 5'd0, 1'b0, 1'b0,
                   1'b1, 5'd8, 32'd44, 1'b0, 1'b1, 5'd7, 32'd55, BYP, 32'd55, 32'd44};
        tbl[8] = '{12'h010, 5'd1, 5'd4, 32'd1, 32'd2, 16'h0000, 1'b0, 5'd0, 1'b0, 1'b0,
                   1'b1, 5'd4, 32'd99, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'd0, 32'd0};
        tbl[9] = '{12'h001, 5'd1, 5'd4, 32'h66, 32'd2, 16'h1234, 1'b1, 5'd0, 1'b0, 1'b1,
                   1'b1, 5'd4, 32'd99, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h66, 32'h1234};

        // Reset state
        set_idle();
        rst = 1'b1;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset alu_control", 32'(alu_control), 32'd0);
        check("reset alu_src1", alu_src1, 32'd0);
        check("reset alu_src2", alu_src2, 32'd0);
        check("reset out_dest", 32'(out_dest), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table, one instruction per cycle with the consumer always ready
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_idle();
            in_valid = 1'b1;
            in_alu_control = tbl[i].op;
            in_rs_addr = tbl[i].rs; in_rt_addr = tbl[i].rt;
            in_rs_val = tbl[i].rsv; in_rt_val = tbl[i].rtv;
            in_imm = tbl[i].imm; in_imm_zext = tbl[i].zext; in_sa = tbl[i].sa;
            in_src1_is_sa = tbl[i].s1sa; in_src2_is_imm = tbl[i].s2imm;
            in_dest = 5'(i + 1);
            mem_wen = tbl[i].mwen; mem_dest = tbl[i].mdest;
            mem_wdata = tbl[i].mdata; mem_is_load = tbl[i].mload;
            wb_wen = tbl[i].wwen; wb_dest = tbl[i].wdest; wb_wdata = tbl[i].wdata;
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ready));
            check($sformatf("vec%0d alu_control", i), 32'(alu_control),
                  tbl[i].ready ? 32'(tbl[i].op) : 32'd0);
            if (tbl[i].ready) begin
                check($sformatf("vec%0d alu_src1", i), alu_src1, tbl[i].src1);
                check($sformatf("vec%0d alu_src2", i), alu_src2, tbl[i].src2);
                check($sformatf("vec%0d out_dest", i), 32'(out_dest), 32'(i + 1));
            end
        end

        // Backpressure for three cycles, then flush
        @(negedge clk);
        set_idle();
        in_valid = 1'b1; in_alu_control = 12'h800;
        in_rs_addr = 5'd1; in_rt_addr = 5'd2; in_rs_val = 32'd5; in_rt_val = 32'd7; in_dest = 5'd9;
        @(posedge clk);
        #1;
        check("bp capture out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        in_rs_val = 32'd100; in_rt_val = 32'd200; in_alu_control = 12'h400;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp alu_control", 32'(alu_control), 32'h800);
            check("bp alu_src1", alu_src1, 32'd5);
            check("bp alu_src2", alu_src2, 32'd7);
            check("bp out_dest", 32'(out_dest), 32'd9);
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        check("flush in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush alu_control", 32'(alu_control), 32'd0);

        // Load-use stall with drain, then capture once the load has left MEM
        @(negedge clk);
        set_idle();
        in_valid = 1'b1; in_alu_control = 12'h080;
        in_rs_addr = 5'd1; in_rt_addr = 5'd2; in_rs_val = 32'd1; in_rt_val = 32'd2;
        @(posedge clk);
        #1;
        check("lu pre out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_alu_control = 12'h040; in_rt_addr = 5'd4; in_rs_val = 32'd3; in_rt_val = 32'd4;
        mem_wen = 1'b1; mem_dest = 5'd4; mem_is_load = 1'b1; mem_wdata = 32'h77;
        #1;
        check("lu in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("lu drain out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        mem_wen = 1'b0; mem_is_load = 1'b0;
        #1;
        check("lu release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("lu capture out_valid", 32'(out_valid), 32'd1);
        check("lu capture alu_control", 32'(alu_control), 32'h040);
        check("lu capture alu_src2", alu_src2, 32'd4);

        // Asynchronous reset between edges while holding a stalled instruction
        @(negedge clk);
        set_idle();
        in_valid = 1'b1; in_alu_control = 12'h010;
        in_rs_val = 32'h11; in_rt_val = 32'h22; in_dest = 5'd3;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_alu_control = 12'h004; in_rs_val = 32'h33; in_rt_val = 32'h44; in_dest = 5'd5;
        #1;
        check("ar stalled in_ready", 32'(in_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("ar out_valid", 32'(out_valid), 32'd0);
        check("ar alu_control", 32'(alu_control), 32'd0);
        check("ar alu_src1", alu_src1, 32'd0);
        check("ar alu_src2", alu_src2, 32'd0);
        check("ar out_dest", 32'(out_dest), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("ar post out_valid", 32'(out_valid), 32'd1);
        check("ar post alu_control", 32'(alu_control), 32'h004);
        check("ar post alu_src1", alu_src1, 32'h33);
        check("ar post out_dest", 32'(out_dest), 32'd5);

        // Randomized run against the model
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        #1 rst = 1'b0;
        m_vld = 1'b0; m_ctrl = '0; m_s1 = '0; m_s2 = '0; m_dest = '0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            in_valid       = ($urandom_range(0, 9) < 7);
            in_alu_control = 12'(12'h001 << $urandom_range(0, 11));
            in_rs_addr     = 5'($urandom_range(0, 3));
            in_rt_addr     = 5'($urandom_range(0, 3));
            in_rs_val      = $urandom;
            in_rt_val      = $urandom;
            in_imm         = 16'($urandom);
            in_imm_zext    = 1'($urandom_range(0, 1));
            in_sa          = 5'($urandom);
            in_src1_is_sa  = ($urandom_range(0, 3) == 0);
            in_src2_is_imm = ($urandom_range(0, 2) == 0);
            in_dest        = 5'($urandom);
            flush          = ($urandom_range(0, 9) == 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            mem_wen        = 1'($urandom_range(0, 1));
            mem_dest       = 5'($urandom_range(0, 3));
            mem_wdata      = $urandom;
            mem_is_load    = ($urandom_range(0, 2) == 0);
            wb_wen         = 1'($urandom_range(0, 1));
            wb_dest        = 5'($urandom_range(0, 3));
            wb_wdata       = $urandom;
            #1;
            exp_rdy = flush || ((!m_vld || out_ready) && !model_stall());
            n_s1 = in_src1_is_sa ? 32'(in_sa) : model_read(in_rs_addr, in_rs_val);
            n_s2 = in_src2_is_imm ? model_imm() : model_read(in_rt_addr, in_rt_val);
            check("rnd in_ready", 32'(in_ready), 32'(exp_rdy));
            @(posedge clk);
            if (flush) begin
                m_vld = 1'b0;
            end else if (in_valid && exp_rdy) begin
                m_vld = 1'b1; m_ctrl = in_alu_control; m_s1 = n_s1; m_s2 = n_s2; m_dest = in_dest;
            end else if (out_ready) begin
                m_vld = 1'b0;
            end
            #1;
            check("rnd out_valid", 32'(out_valid), 32'(m_vld));
            check("rnd alu_control", 32'(alu_control), m_vld ? 32'(m_ctrl) : 32'd0);
            if (m_vld) begin
                check("rnd alu_src1", alu_src1, m_s1);
                check("rnd alu_src2", alu_src2, m_s2);
                check("rnd out_dest", 32'(out_dest), 32'(m_dest));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
